monitor_display7s: RTL and testbench

MONITOR_DISPLAY7S -- requirements
Module: monitor_display7s

---
 rtl/monitor_display7s_pkg.sv | 39 +++
 rtl/monitor_display7s_decodificador_7s.sv | 47 ++++
 rtl/monitor_display7s.sv | 168 ++++++++++++++++
 tb/tb_monitor_display7s.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/monitor_display7s_pkg.sv
// Shared definitions for the seven-segment adder monitor: glyph table,
// controller state encoding and the registered sample-vector layout.
package monitor_display7s_pkg;

    localparam int unsigned VEC_W = 22;

    localparam logic [6:0] GLIFO_0 = 7'h3F;
    localparam logic [6:0] GLIFO_1 = 7'h06;
    localparam logic [6:0] GLIFO_2 = 7'h5B;
    localparam logic [6:0] GLIFO_3 = 7'h4F;
    localparam logic [6:0] GLIFO_4 = 7'h66;
    localparam logic [6:0] GLIFO_5 = 7'h6D;
    localparam logic [6:0] GLIFO_6 = 7'h7D;
    localparam logic [6:0] GLIFO_7 = 7'h07;
    localparam logic [6:0] GLIFO_8 = 7'h7F;
    localparam logic [6:0] GLIFO_9 = 7'h6F;
    localparam logic [6:0] GLIFO_A = 7'h77;
    localparam logic [6:0] GLIFO_B = 7'h7C;
    localparam logic [6:0] GLIFO_C = 7'h39;
    localparam logic [6:0] GLIFO_D = 7'h5E;
    localparam logic [6:0] GLIFO_E = 7'h79;
    localparam logic [6:0] GLIFO_F = 7'h71;

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        ESTABLE    = 3'd1,
        DECODIFICA = 3'd2,
        VERIFICA   = 3'd3,
        REPORTA    = 3'd4
    } estado_t;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic [6:0] r;
        logic       c;
    } muestra_t;

endpackage

// File: rtl/monitor_display7s_decodificador_7s.sv
// Combinational segment-pattern to hex-nibble decoder with invalid-glyph flag.
// Macro SEGMENTOS_ACTIVO_BAJO_EN selects common-anode (inverted) segment inputs.
module decodificador_7s
    import monitor_display7s_pkg::*;
(
    input  logic [6:0] segmentos,
    output logic [3:0] nibble,
    output logic       invalido
);

    logic [6:0] seg_s;

`ifdef SEGMENTOS_ACTIVO_BAJO_EN
    assign seg_s = ~segmentos;
`else
    assign seg_s = segmentos;
`endif

    // Glyph lookup; anything outside the 16 hex glyphs reads as 0 and is flagged
    always_comb begin
        nibble   = 4'h0;
        invalido = 1'b0;
        case (seg_s)
            GLIFO_0: nibble = 4'h0;
            GLIFO_1: nibble = 4'h1;
            GLIFO_2: nibble = 4'h2;
            GLIFO_3: nibble = 4'h3;
            GLIFO_4: nibble = 4'h4;
            GLIFO_5: nibble = 4'h5;
            GLIFO_6: nibble = 4'h6;
            GLIFO_7: nibble = 4'h7;
            GLIFO_8: nibble = 4'h8;
            GLIFO_9: nibble = 4'h9;
            GLIFO_A: nibble = 4'hA;
            GLIFO_B: nibble = 4'hB;
            GLIFO_C: nibble = 4'hC;
            GLIFO_D: nibble = 4'hD;
            GLIFO_E: nibble = 4'hE;
            GLIFO_F: nibble = 4'hF;
            default: begin
                nibble   = 4'h0;
                invalido = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/monitor_display7s.sv
// Monitors three seven-segment displays plus carry of an adder, waits for a stable
// vector, decodes and checks X+Y against the result, and reports it with handshake.
module monitor_display7s
    import monitor_display7s_pkg::*;
#(
    parameter int unsigned ESTABLE_CICLOS = 4,
    parameter int unsigned CONT_ANCHO     = 8
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            X_Display,
    input  logic [6:0]            Y_Display,
    input  logic [6:0]            Resultado_Display,
    input  logic                  CarriSalida,
    input  logic                  Listo,
    output logic                  Valido,
    output logic [3:0]            X_Dec,
    output logic [3:0]            Y_Dec,
    output logic [3:0]            Resultado_Dec,
    output logic                  Error,
    output logic                  PatronInvalido,
    output logic [CONT_ANCHO-1:0] ContOk,
    output logic [CONT_ANCHO-1:0] ContError
);

    localparam logic [7:0]            OBJETIVO = 8'(ESTABLE_CICLOS);
    localparam logic [CONT_ANCHO-1:0] CONT_MAX = {CONT_ANCHO{1'b1}};
    localparam logic [CONT_ANCHO-1:0] CONT_UNO = {{(CONT_ANCHO-1){1'b0}}, 1'b1};

    estado_t               estado_r, estado_s;
    muestra_t              muestra_r, ref_r, ref_s, ultimo_r;
    logic                  primero_r;
    logic [7:0]            cnt_r, cnt_s;
    logic                  estable_s, acepta_s, valido_r, valido_s;
    logic [3:0]            x_nib_s, y_nib_s, r_nib_s;
    logic                  x_inv_s, y_inv_s, r_inv_s;
    logic [3:0]            x_dec_r, y_dec_r, r_dec_r;
    logic                  inv_r, error_r;
    logic [CONT_ANCHO-1:0] ok_r, err_r;

    // The decoders always look at the held candidate, so input churn after stability is ignored
    decodificador_7s u_dec_x (.segmentos(ref_r.x), .nibble(x_nib_s), .invalido(x_inv_s));
    decodificador_7s u_dec_y (.segmentos(ref_r.y), .nibble(y_nib_s), .invalido(y_inv_s));
    decodificador_7s u_dec_r (.segmentos(ref_r.r), .nibble(r_nib_s), .invalido(r_inv_s));

    assign estable_s = (cnt_r >= OBJETIVO) ||
                       ((muestra_r == ref_r) && ((cnt_r + 8'd1) >= OBJETIVO));

    // Next-state and handshake decode
    always_comb begin
        estado_s = estado_r;
        cnt_s    = cnt_r;
        ref_s    = ref_r;
        valido_s = valido_r;
        acepta_s = 1'b0;
        case (estado_r)
            ESPERA: begin
                if (primero_r || (muestra_r != ultimo_r)) begin
                    estado_s = ESTABLE;
                    ref_s    = muestra_r;
                    cnt_s    = 8'd1;
                end else begin
                    estado_s = ESPERA;
                end
            end
            ESTABLE: begin
                if (estable_s) begin
                    // Settling back onto the last reported vector is not news
                    if (!primero_r && (ref_r == ultimo_r)) begin
                        estado_s = ESPERA;
                    end else begin
                        estado_s = DECODIFICA;
                    end
                end else if (muestra_r == ref_r) begin
                    cnt_s = cnt_r + 8'd1;
                end else begin
                    ref_s = muestra_r;
                    cnt_s = 8'd1;
                end
            end
            DECODIFICA: estado_s = VERIFICA;
            VERIFICA: begin
                estado_s = REPORTA;
                valido_s = 1'b1;
            end
            REPORTA: begin
                if (valido_r && Listo) begin
                    acepta_s = 1'b1;
                    valido_s = 1'b0;
                    estado_s = ESPERA;
                end else begin
                    estado_s = REPORTA;
                end
            end
            default: begin
                estado_s = ESPERA;
                valido_s = 1'b0;
            end
        endcase
    end

    // Controller state, sampling and stability tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r  <= ESPERA;
            muestra_r <= '0;
            ref_r     <= '0;
            cnt_r     <= 8'd0;
            valido_r  <= 1'b0;
        end else begin
            estado_r  <= estado_s;
            muestra_r <= {X_Display, Y_Display, Resultado_Display, CarriSalida};
            ref_r     <= ref_s;
            cnt_r     <= cnt_s;
            valido_r  <= valido_s;
        end
    end

    // Decoded report data, captured once per candidate and then held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_dec_r <= 4'h0;
            y_dec_r <= 4'h0;
            r_dec_r <= 4'h0;
            inv_r   <= 1'b0;
            error_r <= 1'b0;
        end else begin
            if (estado_r == DECODIFICA) begin
                x_dec_r <= x_nib_s;
                y_dec_r <= y_nib_s;
                r_dec_r <= r_nib_s;
                inv_r   <= x_inv_s | y_inv_s | r_inv_s;
            end
            if (estado_r == VERIFICA) begin
                error_r <= inv_r |
                           ({ref_r.c, r_dec_r} != ({1'b0, x_dec_r} + {1'b0, y_dec_r}));
            end
        end
    end

    // Acceptance bookkeeping: last reported vector and saturating outcome counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ultimo_r  <= '0;
            primero_r <= 1'b1;
            ok_r      <= '0;
            err_r     <= '0;
        end else if (acepta_s) begin
            ultimo_r  <= ref_r;
            primero_r <= 1'b0;
            if (error_r) begin
                if (err_r != CONT_MAX) err_r <= err_r + CONT_UNO;
            end else begin
                if (ok_r != CONT_MAX) ok_r <= ok_r + CONT_UNO;
            end
        end
    end

    assign Valido         = valido_r;
    assign X_Dec          = x_dec_r;
    assign Y_Dec          = y_dec_r;
    assign Resultado_Dec  = r_dec_r;
    assign Error          = error_r;
    assign PatronInvalido = inv_r;
    assign ContOk         = ok_r;
    assign ContError      = err_r;

endmodule

// File: tb/tb_monitor_display7s.sv
// Randomized self-checking bench for monitor_display7s against a report-level model.
module tb_monitor_display7s;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] X_Display, Y_Display, Resultado_Display;
    logic       CarriSalida, Listo;
    logic       Valido, Error, PatronInvalido;
    logic [3:0] X_Dec, Y_Dec, Resultado_Dec;
    logic [7:0] ContOk, ContError;
    logic       v2, e2, p2;
    logic [3:0] xd2, yd2, rd2;
    logic [1:0] ok2, er2;

    monitor_display7s #(.ESTABLE_CICLOS(N), .CONT_ANCHO(8)) dut (
        .clk(clk), .rst_n(rst_n), .X_Display(X_Display), .Y_Display(Y_Display),
        .Resultado_Display(Resultado_Display), .CarriSalida(CarriSalida), .Listo(Listo),
        .Valido(Valido), .X_Dec(X_Dec), .Y_Dec(Y_Dec), .Resultado_Dec(Resultado_Dec),
        .Error(Error), .PatronInvalido(PatronInvalido), .ContOk(ContOk), .ContError(ContError)
    );

    monitor_display7s #(.ESTABLE_CICLOS(N), .CONT_ANCHO(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .X_Display(X_Display), .Y_Display(Y_Display),
        .Resultado_Display(Resultado_Display), .CarriSalida(CarriSalida), .Listo(Listo),
        .Valido(v2), .X_Dec(xd2), .Y_Dec(yd2), .Resultado_Dec(rd2),
        .Error(e2), .PatronInvalido(p2), .ContOk(ok2), .ContError(er2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [6:0] glifo [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void ref_decode(input logic [6:0] pin, output logic [3:0] n, output logic bad);
        logic [6:0] p;
`ifdef SEGMENTOS_ACTIVO_BAJO_EN
        p = ~pin;
`else
        p = pin;
`endif
        n = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (p == glifo[i]) begin
                n = 4'(i);
                bad = 1'b0;
            end
        end
    endfunction

    // Model state: input history per clock edge plus the report/acceptance ledger
    logic [21:0] hist [0:8191];
    int          cyc;
    int          m_ok, m_err, reports;
    bit          have_last, prev_valid;
    logic [21:0] last_acc, rep_vec;
    logic [14:0] rep_snap;
    logic        rep_err;

    task automatic drive(input logic [21:0] v);
        logic [21:0] p;
        p = v;
`ifdef SEGMENTOS_ACTIVO_BAJO_EN
        p = {~v[21:1], v[0]};
`endif
        X_Display = p[21:15];
        Y_Display = p[14:8];
        Resultado_Display = p[7:1];
        CarriSalida = p[0];
    endtask

    function automatic logic [21:0] gen_vec();
        int dx, dy, s;
        logic [6:0] px, pr;
        logic c;
        dx = $urandom_range(0, 15);
        dy = $urandom_range(0, 15);
        s = dx + dy;
        px = glifo[dx];
        if ($urandom_range(0, 7) == 0) px = 7'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            pr = glifo[s % 16];
            c = (s >= 16);
        end else begin
            pr = glifo[$urandom_range(0, 15)];
            c = 1'($urandom);
        end
        return {px, glifo[dy], pr, c};
    endfunction

    task automatic tick();
        logic l_edge;
        bit v_before, st;
        int k;
        logic [3:0] nx, ny, nr;
        logic bx, by, br, inv, er;
        logic [4:0] sum;
        @(posedge clk);
        hist[cyc] = rst_n ? {X_Display, Y_Display, Resultado_Display, CarriSalida} : 22'd0;
        l_edge = Listo;
        v_before = prev_valid;
        cyc++;
        @(negedge clk);
        if (!rst_n) begin
            prev_valid = 1'b0;
            return;
        end
        if (v_before && l_edge) begin
            if (rep_err) m_err = (m_err < 255) ? m_err + 1 : 255;
            else m_ok = (m_ok < 255) ? m_ok + 1 : 255;
            have_last = 1'b1;
            last_acc = rep_vec;
            check_val("accept_drop", Valido, 1'b0);
            check_val("cont_ok", ContOk, m_ok);
            check_val("cont_err", ContError, m_err);
        end else if (v_before) begin
            check_val("hold_valid", Valido, 1'b1);
            check_val("hold_data", {X_Dec, Y_Dec, Resultado_Dec, Error, PatronInvalido}, rep_snap);
        end else if (Valido) begin
            // A report must carry the vector held for the N samples ending three edges back
            k = cyc - 1;
            rep_vec = hist[k-3];
            st = 1'b1;
            for (int j = k - N - 2; j <= k - 3; j++) if (hist[j] != rep_vec) st = 1'b0;
            check_val("stable_window", st, 1'b1);
            if (have_last) check_val("no_repeat", rep_vec != last_acc, 1'b1);
            ref_decode(rep_vec[21:15], nx, bx);
            ref_decode(rep_vec[14:8], ny, by);
            ref_decode(rep_vec[7:1], nr, br);
            inv = bx | by | br;
            sum = 5'(nx) + 5'(ny);
            er = inv | ({rep_vec[0], nr} != sum);
            check_val("report", {X_Dec, Y_Dec, Resultado_Dec, Error, PatronInvalido},
                      {nx, ny, nr, er, inv});
            check_val("dut2_valid", v2, 1'b1);
            rep_err = er;
            rep_snap = {nx, ny, nr, er, inv};
            reports++;
        end
        prev_valid = Valido;
    endtask

    task automatic wait_report(input string tag, input int budget);
        int r0;
        r0 = reports;
        for (int i = 0; i < budget && reports == r0; i++) tick();
        check_val(tag, reports > r0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("reset_out", {Valido, Error, PatronInvalido, X_Dec, Y_Dec, Resultado_Dec, ContOk, ContError}, 32'd0);
        check_val("reset_dut2", {v2, e2, p2, xd2, yd2, rd2, ok2, er2}, 32'd0);
        m_ok = 0;
        m_err = 0;
        have_last = 1'b0;
        prev_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int t, r0;
        logic [21:0] va, vb;
        for (int i = 0; i < 8192; i++) hist[i] = 22'd0;
        cyc = 16;
        reports = 0;
        rep_err = 1'b0;
        rep_snap = 15'd0;
        rep_vec = 22'd0;
        last_acc = 22'd0;
        Listo = 1'b0;
        drive(22'd0);
        do_reset();

        // Basic pass: 3 + 5 = 8, exact latency from the first sampling edge
        drive({7'h4F, 7'h6D, 7'h7F, 1'b0});
        Listo = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!Valido && t < 30);
        check_val("latency", t, N + 3);
        check_val("d1_nibbles", {X_Dec, Y_Dec, Resultado_Dec, Error}, {4'h3, 4'h5, 4'h8, 1'b0});
        tick();
        check_val("d1_ok", ContOk, 8'd1);

        // 7 + 9 = 0x10 with carry passes; same digits without carry fails
        drive({7'h07, 7'h6F, 7'h3F, 1'b1});
        wait_report("d2_report", 30);
        check_val("d2_err0", Error, 1'b0);
        tick();
        drive({7'h07, 7'h6F, 7'h3F, 1'b0});
        wait_report("d2b_report", 30);
        check_val("d2_err1", Error, 1'b1);
        tick();
        check_val("d2_cont_err", ContError, 8'd1);

        // Inputs toggling faster than the stability window never report
        va = {glifo[1], glifo[2], glifo[3], 1'b0};
        vb = {glifo[4], glifo[4], glifo[8], 1'b0};
        r0 = reports;
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 1) ? va : vb);
            repeat (3) tick();
        end
        check_val("toggle_quiet", reports, r0);
        wait_report("toggle_hold", 30);
        r0 = reports;
        repeat (30) tick();
        check_val("no_rereport", reports, r0);

        // Blank X display is not a glyph
        drive({7'h00, glifo[2], glifo[2], 1'b0});
        wait_report("inv_report", 30);
        check_val("inv_flags", {PatronInvalido, X_Dec, Error}, {1'b1, 4'h0, 1'b1});
        tick();

        // Consumer stalls while inputs keep changing
        Listo = 1'b0;
        drive({glifo[6], glifo[1], glifo[7], 1'b0});
        wait_report("stall_report", 30);
        for (int i = 0; i < 10; i++) begin
            drive(gen_vec());
            tick();
        end
        Listo = 1'b1;
        tick();
        drive({glifo[9], glifo[9], glifo[2], 1'b1});
        wait_report("after_stall", 30);
        tick();

        // Random traffic with a randomly stalling consumer
        for (int s = 0; s < 300; s++) begin
            drive(gen_vec());
            for (int h = $urandom_range(1, 9); h > 0; h--) begin
                Listo = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        Listo = 1'b1;
        repeat (12) tick();
        drive({glifo[15], glifo[15], glifo[14], 1'b1});
        wait_report("final_report", 30);
        tick();
        check_val("dut2_sat_ok", ok2, (m_ok > 3) ? 3 : m_ok);
        check_val("dut2_sat_err", er2, (m_err > 3) ? 3 : m_err);
        check_val("enough_passes", m_ok >= 5, 1'b1);

        // Reset while a candidate is settling, then normal operation resumes
        drive({glifo[2], glifo[3], glifo[5], 1'b0});
        repeat (2) tick();
        do_reset();
        repeat (N + 6) tick();
        check_val("post_reset_report", ContOk, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
